pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 130 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: a three-state request/deliver engine with a
// circular return-address stack that overwrites its oldest entry when full.
`timescale 1ns/1ps

module pc_fetch_unit #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [7:0] STEP      = 8'd4,
  parameter int         RAS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       stall,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  input  logic       call,
  input  logic       ret,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       instr_valid,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  output logic       ras_empty,
  output logic       ras_overflow,
  output logic       ras_underflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DELIVER} state_t;

  state_t           r_state, w_next_state;
  logic [7:0]       r_pc, w_next_pc, w_seq_pc;
  logic [7:0]       r_instr, r_instr_pc;
  logic [7:0]       r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_top, w_top_inc, w_top_dec;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow, r_underflow;
  logic             w_full, w_push, w_pop, w_underflow_evt;

  // 8-bit sum wraps naturally, so FC + 4 lands on 00.
  assign w_seq_pc  = r_pc + STEP;
  assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
  // r_top points at the next free slot; both directions wrap for any depth.
  assign w_top_inc = (r_top == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_top + PTR_W'(1);
  assign w_top_dec = (r_top == '0) ? PTR_W'(RAS_DEPTH - 1) : r_top - PTR_W'(1);

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    w_next_state    = r_state;
    w_next_pc       = r_pc;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_underflow_evt = 1'b0;
    case (r_state)
      IDLE:    w_next_state = REQ;
      REQ:     if (mem_ack) w_next_state = DELIVER;
      DELIVER: begin
        if (!stall) begin
          w_next_state = REQ;
          if (ret) begin
            if (r_count != '0) begin
              w_pop     = 1'b1;
              w_next_pc = r_ras[w_top_dec];
            end else begin
              w_underflow_evt = 1'b1;
              w_next_pc       = w_seq_pc;
            end
          end else if (call) begin
            w_push    = 1'b1;
            w_next_pc = redirect_pc;
          end else if (redirect) begin
            w_next_pc = redirect_pc;
          end else begin
            w_next_pc = w_seq_pc;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_instr_pc  <= '0;
      r_top       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (r_state == REQ && mem_ack) begin
        r_instr    <= mem_rdata;
        r_instr_pc <= r_pc;
      end
      if (w_push) begin
        r_top <= w_top_inc;
        if (w_full) r_overflow <= 1'b1;
        else        r_count    <= r_count + CNT_W'(1);
      end else if (w_pop) begin
        r_top   <= w_top_dec;
        r_count <= r_count - CNT_W'(1);
      end
      if (w_underflow_evt) r_underflow <= 1'b1;
    end
  end

  // NOTE: the stack storage has no reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (reset_n && w_push) r_ras[r_top] <= w_seq_pc;
  end

  assign mem_req       = (r_state == REQ);
  assign mem_addr      = mem_req ? r_pc : '0;
  assign instr_valid   = (r_state == DELIVER);
  assign instr         = r_instr;
  assign instr_pc      = r_instr_pc;
  assign ras_empty     = (r_count == '0);
  assign ras_overflow  = r_overflow;
  assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a control-vector table applied in DELIVER,
// plus hand sequences for wait states, stall, and reset with a request pending.
`timescale 1ns/1ps

module tb_pc_fetch_unit;

  logic       clk = 1'b0;
  logic       reset_n, stall, redirect, call, ret;
  logic [7:0] redirect_pc;
  logic       mem_req, mem_ack, instr_valid;
  logic [7:0] mem_addr, mem_rdata, instr, instr_pc;
  logic       ras_empty, ras_overflow, ras_underflow;

  // Memory model: optional zero-wait ack, or a forced ack level; data = addr ^ key.
  logic       auto_ack, force_ack;
  logic [7:0] rdata_xor;
  assign mem_ack   = force_ack | (auto_ack & mem_req);
  assign mem_rdata = mem_addr ^ rdata_xor;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .call(call), .ret(ret),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .ras_empty(ras_empty), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rd, cl, rt;
    logic [7:0] rpc;
    logic [7:0] exp_pc;
    logic       exp_empty, exp_ovf, exp_udf;
  } vec_t;

  vec_t vecs[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ctrl(input logic s, input logic rd, input logic cl, input logic rt,
                          input logic [7:0] rpc);
    stall = s; redirect = rd; call = cl; ret = rt; redirect_pc = rpc;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 10) begin
      tick();
      n++;
    end
    check(name, instr_valid, 1'b1);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0}; // call from 10
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h14, 1'b1, 1'b0, 1'b0}; // ret to 14
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'hF8, 8'hF8, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFC, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}; // FC wraps
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h20, 8'h20, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h30, 8'h30, 1'b0, 1'b0, 1'b0}; // push 24
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0}; // push 34
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h70, 8'h70, 1'b0, 1'b0, 1'b0}; // push 54
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h90, 8'h90, 1'b0, 1'b0, 1'b0}; // push 74
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'hB0, 8'hB0, 1'b0, 1'b1, 1'b0}; // push 94 over 24
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h94, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h74, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h54, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h34, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h38, 1'b1, 1'b1, 1'b1}; // empty ret: 34+4
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'h60, 8'h60, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1}; // push 64
    vecs[18] = '{1'b1, 1'b1, 1'b1, 8'hC0, 8'h64, 1'b1, 1'b1, 1'b1}; // ret wins
    vecs[19] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h68, 1'b1, 1'b1, 1'b1};

    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    auto_ack = 1'b1; force_ack = 1'b0; rdata_xor = 8'h5A;
    reset_n = 1'b0;
    tick(); tick(); tick();

    check("rst mem_req", mem_req, 1'b0);
    check("rst mem_addr", mem_addr, 8'h00);
    check("rst instr_valid", instr_valid, 1'b0);
    check("rst instr", instr, 8'h00);
    check("rst instr_pc", instr_pc, 8'h00);
    check("rst ras_empty", ras_empty, 1'b1);
    check("rst ovf", ras_overflow, 1'b0);
    check("rst udf", ras_underflow, 1'b0);

    // Zero-wait memory: one instruction every two cycles from RESET_PC upward.
    reset_n = 1'b1;
    check("idle mem_req", mem_req, 1'b0);
    tick();
    check("first req", mem_req, 1'b1);
    check("first addr", mem_addr, 8'h00);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("seq%0d valid", i), instr_valid, 1'b1);
      check($sformatf("seq%0d instr_pc", i), instr_pc, 8'(4 * i));
      check($sformatf("seq%0d instr", i), instr, 8'(4 * i) ^ 8'h5A);
      tick();
      check($sformatf("seq%0d gap valid", i), instr_valid, 1'b0);
      check($sformatf("seq%0d next addr", i), mem_addr, 8'(4 * (i + 1)));
      tick();
    end

    // Control vectors, each applied for one DELIVER cycle starting at PC=10.
    for (int v = 0; v < 20; v++) begin
      wait_valid($sformatf("v%0d reach deliver", v));
      set_ctrl(1'b0, vecs[v].rd, vecs[v].cl, vecs[v].rt, vecs[v].rpc);
      tick();
      set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check($sformatf("v%0d mem_req", v), mem_req, 1'b1);
      check($sformatf("v%0d mem_addr", v), mem_addr, vecs[v].exp_pc);
      check($sformatf("v%0d ras_empty", v), ras_empty, vecs[v].exp_empty);
      check($sformatf("v%0d ovf", v), ras_overflow, vecs[v].exp_ovf);
      check($sformatf("v%0d udf", v), ras_underflow, vecs[v].exp_udf);
      tick();
      check($sformatf("v%0d instr_pc", v), instr_pc, vecs[v].exp_pc);
    end

    // Three wait states: request held for four cycles, controls ignored in REQ.
    auto_ack = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      set_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 8'hEE);
      check($sformatf("wait%0d mem_req", k), mem_req, 1'b1);
      check($sformatf("wait%0d mem_addr", k), mem_addr, 8'h6C);
      tick();
    end
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("wait3 mem_req", mem_req, 1'b1);
    check("wait3 mem_addr", mem_addr, 8'h6C);
    force_ack = 1'b1;
    tick();
    check("late ack valid", instr_valid, 1'b1);
    check("late ack instr_pc", instr_pc, 8'h6C);
    check("late ack instr", instr, 8'h6C ^ 8'h5A);
    check("req ctrl ignored", ras_empty, 1'b1);

    // Stall five DELIVER cycles with redirect, stray ack and new memory data.
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
    rdata_xor = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall%0d valid", k), instr_valid, 1'b1);
      check($sformatf("stall%0d instr_pc", k), instr_pc, 8'h6C);
      check($sformatf("stall%0d instr", k), instr, 8'h6C ^ 8'h5A);
      check($sformatf("stall%0d mem_req", k), mem_req, 1'b0);
    end
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    force_ack = 1'b0;
    rdata_xor = 8'h5A;
    tick();
    check("post stall addr", mem_addr, 8'h70);
    check("single deliver", instr_valid, 1'b0);
    tick();
    check("no ack holds req", mem_req, 1'b1);
    check("no ack no valid", instr_valid, 1'b0);

    // Reset while a request is outstanding, then a stray ack during IDLE.
    reset_n = 1'b0;
    tick();
    check("mid rst mem_req", mem_req, 1'b0);
    check("mid rst valid", instr_valid, 1'b0);
    check("mid rst instr", instr, 8'h00);
    check("mid rst instr_pc", instr_pc, 8'h00);
    check("mid rst ras_empty", ras_empty, 1'b1);
    check("mid rst ovf", ras_overflow, 1'b0);
    check("mid rst udf", ras_underflow, 1'b0);
    reset_n = 1'b1;
    force_ack = 1'b1;
    check("idle2 mem_req", mem_req, 1'b0);
    tick();
    force_ack = 1'b0;
    check("idle ack ignored valid", instr_valid, 1'b0);
    check("idle ack ignored instr", instr, 8'h00);
    check("restart req", mem_req, 1'b1);
    check("restart addr", mem_addr, 8'h00);
    tick();
    check("restart waits", instr_valid, 1'b0);
    auto_ack = 1'b1;
    tick();
    check("restart deliver", instr_valid, 1'b1);
    check("restart instr", instr, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
